imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_pkg.sv | 31 +++
 rtl/imm_decode.sv | 80 ++++++++
 rtl/imm_gen_pipe.sv | 164 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: opcode constants, immediate format codes and buffer states
// shared by the immediate-generation pipeline stage and its decoder.
package imm_pkg;

  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_st_e;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RV32 immediate decoder.
// Ports: instr (32) in; imm (XLEN), fmt (fmt_e), illegal out.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SIGN_EXT = 1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0]  w_op;
  logic [31:0] w_se;
  logic [31:0] w_ze;
  logic        w_is_i;
  logic        w_is_u;

  assign w_op   = instr[6:0];
  assign w_is_i = (w_op == OP_OPIMM) || (w_op == OP_LOAD) ||
                  (w_op == OP_JALR)  || (w_op == OP_SYSTEM);
  assign w_is_u = (w_op == OP_LUI) || (w_op == OP_AUIPC);

  // w_se/w_ze hold the 32-bit sign- and zero-extended forms.
  always_comb begin
    fmt  = FMT_NONE;
    w_se = '0;
    w_ze = '0;
    unique case (1'b1)
      w_is_i: begin
        fmt  = FMT_I;
        w_se = {{20{instr[31]}}, instr[31:20]};
        w_ze = {20'b0, instr[31:20]};
      end
      (w_op == OP_STORE): begin
        fmt  = FMT_S;
        w_se = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        w_ze = {20'b0, instr[31:25], instr[11:7]};
      end
      (w_op == OP_BRANCH): begin
        fmt  = FMT_B;
        w_se = {{19{instr[31]}}, instr[31], instr[7],
                instr[30:25], instr[11:8], 1'b0};
        w_ze = {19'b0, instr[31], instr[7],
                instr[30:25], instr[11:8], 1'b0};
      end
      w_is_u: begin
        fmt  = FMT_U;
        w_se = {instr[31:12], 12'b0};
        w_ze = {instr[31:12], 12'b0};
      end
      (w_op == OP_JAL): begin
        fmt  = FMT_J;
        w_se = {{11{instr[31]}}, instr[31], instr[19:12],
                instr[20], instr[30:21], 1'b0};
        w_ze = {11'b0, instr[31], instr[19:12],
                instr[20], instr[30:21], 1'b0};
      end
      default: begin
        fmt  = FMT_NONE;
        w_se = '0;
        w_ze = '0;
      end
    endcase
  end

  // U-format always widens from bit 31 so RV64 LUI/AUIPC match the ISA.
  always_comb begin
    if (SIGN_EXT != 0 || fmt == FMT_U)
      imm = XLEN'($signed(w_se));
    else
      imm = XLEN'(w_ze);
  end

  assign illegal = (instr[1:0] != 2'b11) ||
                   (fmt == FMT_NONE && w_op != OP_OP);

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: 1-cycle immediate-generation stage with a 2-entry skid buffer.
// Ports: clk, rst (async high), flush; in_valid/in_ready/in_instr upstream;
// out_valid/out_ready/out_instr/out_imm/out_fmt downstream;
// out_illegal only when IMM_GEN_ILLEGAL_EN is defined.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SIGN_EXT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  buf_st_e         r_state;
  buf_st_e         w_state_nxt;
  logic            r_in_ready;
  logic            w_in_hs;
  logic            w_out_hs;
  logic            w_ld_main_in;
  logic            w_ld_main_skid;
  logic            w_ld_skid;

  logic [XLEN-1:0] w_imm;
  fmt_e            w_fmt;
  logic            w_illegal;

  logic [31:0]     r_m_instr;
  logic [XLEN-1:0] r_m_imm;
  fmt_e            r_m_fmt;
  logic [31:0]     r_s_instr;
  logic [XLEN-1:0] r_s_imm;
  fmt_e            r_s_fmt;

  imm_decode #(
    .XLEN    (XLEN),
    .SIGN_EXT(SIGN_EXT)
  ) u_dec (
    .instr  (in_instr),
    .imm    (w_imm),
    .fmt    (w_fmt),
    .illegal(w_illegal)
  );

  assign w_in_hs  = in_valid && r_in_ready;
  assign w_out_hs = out_valid && out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_hs) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_hs && w_out_hs) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_hs) begin
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_out_hs) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_hs) begin
            w_state_nxt    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready is its own flop so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_instr <= '0;
      r_m_imm   <= '0;
      r_m_fmt   <= FMT_NONE;
      r_s_instr <= '0;
      r_s_imm   <= '0;
      r_s_fmt   <= FMT_NONE;
    end else begin
      if (w_ld_main_in) begin
        r_m_instr <= in_instr;
        r_m_imm   <= w_imm;
        r_m_fmt   <= w_fmt;
      end else if (w_ld_main_skid) begin
        r_m_instr <= r_s_instr;
        r_m_imm   <= r_s_imm;
        r_m_fmt   <= r_s_fmt;
      end
      if (w_ld_skid) begin
        r_s_instr <= in_instr;
        r_s_imm   <= w_imm;
        r_s_fmt   <= w_fmt;
      end
    end
  end

`ifdef IMM_GEN_ILLEGAL_EN
  logic r_m_ill;
  logic r_s_ill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_ill <= 1'b0;
      r_s_ill <= 1'b0;
    end else begin
      if (w_ld_main_in)
        r_m_ill <= w_illegal;
      else if (w_ld_main_skid)
        r_m_ill <= r_s_ill;
      if (w_ld_skid)
        r_s_ill <= w_illegal;
    end
  end

  assign out_illegal = r_m_ill;
`else
  logic w_unused;
  assign w_unused = w_illegal;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_instr = r_m_instr;
  assign out_imm   = r_m_imm;
  assign out_fmt   = r_m_fmt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe (XLEN 32/64, SIGN_EXT 0/1),
// covering decode vectors, stall, flush and async reset.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush;
  logic in_valid;
  logic [31:0] in_instr;
  logic out_ready;

  logic        a_rdy, a_vld;
  logic [31:0] a_instr;
  logic [31:0] a_imm;
  logic [2:0]  a_fmt;
  logic        z_rdy, z_vld;
  logic [31:0] z_instr;
  logic [31:0] z_imm;
  logic [2:0]  z_fmt;
  logic        w_rdy, w_vld;
  logic [31:0] w_instr;
  logic [63:0] w_imm;
  logic [2:0]  w_fmt;
`ifdef IMM_GEN_ILLEGAL_EN
  logic a_ill, z_ill, w_ill;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_rdy), .in_instr(in_instr),
    .out_valid(a_vld), .out_ready(out_ready),
    .out_instr(a_instr), .out_imm(a_imm), .out_fmt(a_fmt)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_illegal(a_ill)
`endif
  );

  imm_gen_pipe #(.XLEN(32), .SIGN_EXT(0)) dut_z (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(z_rdy), .in_instr(in_instr),
    .out_valid(z_vld), .out_ready(out_ready),
    .out_instr(z_instr), .out_imm(z_imm), .out_fmt(z_fmt)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_illegal(z_ill)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(w_rdy), .in_instr(in_instr),
    .out_valid(w_vld), .out_ready(out_ready),
    .out_instr(w_instr), .out_imm(w_imm), .out_fmt(w_fmt)
`ifdef IMM_GEN_ILLEGAL_EN
    , .out_illegal(w_ill)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  logic [31:0] v_w   [8];
  logic [2:0]  v_fmt [8];
  logic [31:0] v_i32 [8];
  logic [31:0] v_iz  [8];
  logic [63:0] v_i64 [8];
  logic        v_ill [8];

  initial begin
    v_w[0] = 32'hFFF00093; v_fmt[0] = 3'd1; v_i32[0] = 32'hFFFFFFFF;
    v_iz[0] = 32'h00000FFF; v_i64[0] = 64'hFFFFFFFFFFFFFFFF; v_ill[0] = 0;
    v_w[1] = 32'h0020A423; v_fmt[1] = 3'd2; v_i32[1] = 32'h00000008;
    v_iz[1] = 32'h00000008; v_i64[1] = 64'h8; v_ill[1] = 0;
    v_w[2] = 32'hFE000EE3; v_fmt[2] = 3'd3; v_i32[2] = 32'hFFFFFFFC;
    v_iz[2] = 32'h00001FFC; v_i64[2] = 64'hFFFFFFFFFFFFFFFC; v_ill[2] = 0;
    v_w[3] = 32'h123452B7; v_fmt[3] = 3'd4; v_i32[3] = 32'h12345000;
    v_iz[3] = 32'h12345000; v_i64[3] = 64'h12345000; v_ill[3] = 0;
    v_w[4] = 32'h0010006F; v_fmt[4] = 3'd5; v_i32[4] = 32'h00000800;
    v_iz[4] = 32'h00000800; v_i64[4] = 64'h800; v_ill[4] = 0;
    v_w[5] = 32'h800002B7; v_fmt[5] = 3'd4; v_i32[5] = 32'h80000000;
    v_iz[5] = 32'h80000000; v_i64[5] = 64'hFFFFFFFF80000000; v_ill[5] = 0;
    v_w[6] = 32'h00000033; v_fmt[6] = 3'd0; v_i32[6] = 32'h0;
    v_iz[6] = 32'h0; v_i64[6] = 64'h0; v_ill[6] = 0;
    v_w[7] = 32'h00000000; v_fmt[7] = 3'd0; v_i32[7] = 32'h0;
    v_iz[7] = 32'h0; v_i64[7] = 64'h0; v_ill[7] = 1;
  end

  initial begin
    flush = 0; in_valid = 0; in_instr = 0; out_ready = 1;
    #1 rst = 1;
    #2;
    check("rst_vld", a_vld, 0);
    check("rst_rdy", a_rdy, 1);
    check("rst_instr", a_instr, 0);
    check("rst_imm", a_imm, 0);
    check("rst_fmt", a_fmt, 0);
    @(negedge clk);
    rst = 0;

    // streaming: every accept after the first overlaps a drain
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("v%0d_vld", i-1), a_vld, 1);
        check($sformatf("v%0d_instr", i-1), a_instr, v_w[i-1]);
        check($sformatf("v%0d_fmt", i-1), a_fmt, v_fmt[i-1]);
        check($sformatf("v%0d_imm", i-1), a_imm, v_i32[i-1]);
        check($sformatf("v%0d_immz", i-1), z_imm, v_iz[i-1]);
        check($sformatf("v%0d_imm64", i-1), w_imm, v_i64[i-1]);
`ifdef IMM_GEN_ILLEGAL_EN
        check($sformatf("v%0d_ill", i-1), w_ill, v_ill[i-1]);
`endif
      end
      if (i < 8) begin
        in_valid = 1; in_instr = v_w[i];
      end else begin
        in_valid = 0;
      end
    end
    @(negedge clk);
    check("drain_vld", a_vld, 0);

    // stall: three back-to-back words with out_ready low
    out_ready = 0;
    check("st_rdy1", a_rdy, 1);
    in_valid = 1; in_instr = 32'hFFF00093;
    @(negedge clk);
    check("st_rdy2", a_rdy, 1);
    in_instr = 32'h0020A423;
    @(negedge clk);
    check("st_rdy3", a_rdy, 0);
    in_instr = 32'hFE000EE3;
    @(negedge clk);
    in_valid = 0;
    check("st_vld_a", a_vld, 1);
    check("st_instr_a", a_instr, 32'hFFF00093);
    @(negedge clk);
    check("st_hold_a", a_instr, 32'hFFF00093);
    check("st_hold_imm", a_imm, 32'hFFFFFFFF);
    out_ready = 1;
    @(negedge clk);
    check("st_vld_b", a_vld, 1);
    check("st_instr_b", a_instr, 32'h0020A423);
    check("st_imm_b", a_imm, 32'h00000008);
    @(negedge clk);
    check("st_empty", a_vld, 0);

    // flush while FULL with an input offered
    out_ready = 0;
    in_valid = 1; in_instr = 32'h123452B7;
    @(negedge clk);
    in_instr = 32'h0010006F;
    @(negedge clk);
    check("fl_full", a_rdy, 0);
    flush = 1; in_instr = 32'h800002B7;
    @(negedge clk);
    flush = 0; in_valid = 0;
    check("fl_vld", a_vld, 0);
    check("fl_rdy", a_rdy, 1);
    @(negedge clk);
    check("fl_vld2", a_vld, 0);

    // async reset between edges while FULL
    in_valid = 1; in_instr = 32'hFFF00093;
    @(negedge clk);
    in_instr = 32'h0020A423;
    @(negedge clk);
    in_valid = 0;
    check("rs_full", a_rdy, 0);
    #2 rst = 1;
    #1;
    check("rs_vld", a_vld, 0);
    check("rs_rdy", a_rdy, 1);
    check("rs_instr", a_instr, 0);
    check("rs_imm", a_imm, 0);
    check("rs_fmt", a_fmt, 0);
    check("rs_imm64", w_imm, 0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    in_valid = 1; in_instr = 32'h0010006F;
    @(negedge clk);
    in_valid = 0;
    check("rs_first_vld", a_vld, 1);
    check("rs_first_imm", a_imm, 32'h00000800);
    @(negedge clk);
    check("rs_no_skid", a_vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
